// File: rtl/ilowx_line_server.sv
// ilowx_line_server: responder for icache miss requests. Reads a full line
// (or a single word for uncached requests) over a pipelined, in-order memory
// read bus, assembles the words into one block and hands it back to the
// icache as a single-cycle response.
module ilowx_line_server #(
    parameter int BLK_SIZE = 128,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lowx_req_valid_i,
    input  logic                lowx_req_ready_i,
    input  logic [XLEN-1:0]     lowx_req_addr_i,
    input  logic                lowx_req_uncached_i,
    output logic                lowx_res_valid_o,
    output logic [BLK_SIZE-1:0] lowx_res_blk_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [XLEN-1:0]     mem_rsp_data_i,
    output logic                busy_o
);
    localparam int BEATS  = BLK_SIZE / XLEN;
    localparam int OFF_W  = $clog2(BLK_SIZE / 8);
    localparam int WB     = $clog2(XLEN / 8);
    localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, RESP, COOL} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [XLEN-1:0]       base_q;
    logic [CNT_W-1:0]      nbeats_q;
    logic [CNT_W-1:0]      iss_q;
    logic [CNT_W-1:0]      rcv_q;
    logic                  uncached_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  live_q;
    logic [BLK_SIZE-1:0]   buf_q;

    logic [XLEN-1:0]       line_base;
    logic [XLEN-1:0]       word_base;
    logic [LANE_W-1:0]     req_lane;
    logic [LANE_W-1:0]     word_idx;
    logic                  issue_fire;
    logic                  rsp_fire;
    logic                  last_rsp;
    logic                  live_now;

    assign line_base  = {lowx_req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign word_base  = {lowx_req_addr_i[XLEN-1:WB], {WB{1'b0}}};
    assign req_lane   = LANE_W'(lowx_req_addr_i >> WB);
    assign word_idx   = uncached_q ? lane_q : LANE_W'(rcv_q);
    assign issue_fire = mem_req_valid_o && mem_req_ready_i;
    assign rsp_fire   = (state_q == FETCH) && mem_rsp_valid_i && (rcv_q < nbeats_q);
    assign last_rsp   = rsp_fire && (rcv_q == nbeats_q - 1'b1);
    // The request only counts as live if the icache never dropped it since latch.
    assign live_now   = live_q && lowx_req_valid_i;

    assign mem_req_addr_o = base_q + (XLEN'(iss_q) << WB);
    assign lowx_res_blk_o = buf_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: outstanding beats always drain before leaving FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (lowx_req_valid_i) state_d = FETCH;
            FETCH: if (last_rsp) state_d = live_now ? RESP : COOL;
            RESP:  if (!lowx_req_valid_i || lowx_req_ready_i) state_d = COOL;
            COOL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        mem_req_valid_o  = 1'b0;
        lowx_res_valid_o = 1'b0;
        busy_o           = 1'b1;
        case (state_q)
            IDLE:  busy_o = 1'b0;
            FETCH: mem_req_valid_o = (iss_q < nbeats_q);
            RESP:  lowx_res_valid_o = lowx_req_ready_i && lowx_req_valid_i;
            default: ;
        endcase
    end

    // Request latch, issue/receive counters and line assembly buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q     <= '0;
            nbeats_q   <= '0;
            iss_q      <= '0;
            rcv_q      <= '0;
            uncached_q <= 1'b0;
            lane_q     <= '0;
            live_q     <= 1'b0;
            buf_q      <= '0;
        end else if (state_q == IDLE) begin
            if (lowx_req_valid_i) begin
                base_q     <= lowx_req_uncached_i ? word_base : line_base;
                nbeats_q   <= lowx_req_uncached_i ? CNT_W'(1) : CNT_W'(BEATS);
                uncached_q <= lowx_req_uncached_i;
                lane_q     <= req_lane;
                live_q     <= 1'b1;
                iss_q      <= '0;
                rcv_q      <= '0;
                buf_q      <= '0;
            end
        end else if (state_q == FETCH) begin
            live_q <= live_now;
            if (issue_fire) begin
                iss_q <= iss_q + 1'b1;
            end
            if (rsp_fire) begin
                buf_q[word_idx*XLEN +: XLEN] <= mem_rsp_data_i;
                rcv_q                        <= rcv_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ilowx_line_server.sv
// tb_ilowx_line_server: randomized bench with a queue-based memory model and
// a line-level reference model for the expected block and address sequence.
module tb_ilowx_line_server;
    localparam int BLK_SIZE = 128;
    localparam int XLEN     = 32;
    localparam int BEATS    = 4;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                lowx_req_valid_i = 1'b0;
    logic                lowx_req_ready_i = 1'b0;
    logic [XLEN-1:0]     lowx_req_addr_i = '0;
    logic                lowx_req_uncached_i = 1'b0;
    logic                lowx_res_valid_o;
    logic [BLK_SIZE-1:0] lowx_res_blk_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i = 1'b0;
    logic [XLEN-1:0]     mem_req_addr_o;
    logic                mem_rsp_valid_i = 1'b0;
    logic [XLEN-1:0]     mem_rsp_data_i = '0;
    logic                busy_o;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          last_due = 0;
    int          acc_cnt = 0;
    int          deliv_cnt = 0;
    int          pat_idx = 0;
    int          ready_mode = 0;
    int          lat_mode = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] acc_addr[$];
    logic [31:0] seed = 32'h0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = 32'h0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    bit          ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    ilowx_line_server #(.BLK_SIZE(BLK_SIZE), .XLEN(XLEN)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .lowx_req_valid_i    (lowx_req_valid_i),
        .lowx_req_ready_i    (lowx_req_ready_i),
        .lowx_req_addr_i     (lowx_req_addr_i),
        .lowx_req_uncached_i (lowx_req_uncached_i),
        .lowx_res_valid_o    (lowx_res_valid_o),
        .lowx_res_blk_o      (lowx_res_blk_o),
        .mem_req_valid_o     (mem_req_valid_o),
        .mem_req_ready_i     (mem_req_ready_i),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_rsp_valid_i     (mem_rsp_valid_i),
        .mem_rsp_data_i      (mem_rsp_data_i),
        .busy_o              (busy_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Contents of memory word at address a for the current transaction.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return force_en ? force_val : ((a * 32'h9E37_79B1) ^ seed);
    endfunction

    // Memory model: in-order pipelined read responder with configurable backpressure.
    always @(negedge clk_i) begin : mem_model
        bit r;
        int lat;
        int due;
        cyc = cyc + 1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = dat_q.pop_front();
            due_q.delete(0);
            deliv_cnt = deliv_cnt + 1;
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = $urandom;
        end
        if (ready_mode == 1 && mem_req_valid_o) begin
            r = (pat_idx < 7) ? ready_pat[pat_idx] : 1'b1;
            pat_idx = pat_idx + 1;
        end else if (ready_mode == 2) begin
            r = ($urandom_range(0, 2) != 0);
        end else begin
            r = 1'b1;
        end
        mem_req_ready_i = r;
        if (mem_req_valid_o) begin
            if (hold_pending) checkOutput("addr_hold", mem_req_addr_o, hold_addr);
            if (r) begin
                lat = (lat_mode == 0) ? 2 : $urandom_range(1, 3);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                acc_addr.push_back(mem_req_addr_o);
                acc_cnt = acc_cnt + 1;
                due_q.push_back(due);
                dat_q.push_back(memWord(mem_req_addr_o));
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                hold_addr    = mem_req_addr_o;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Drive the icache side for one miss and check the outcome against the line model.
    task automatic applyStimulus(input logic [31:0] a, input bit unc, input int rmode, input int lmode,
                                 input int stall, input int drop_at, input int rst_at);
        logic [127:0] exp_blk;
        logic [31:0]  base;
        int nb;
        int lane;
        int prev_acc = 0;
        int prev_deliv = 0;
        int stalls = 0;
        int pulses = 0;
        bit dropped = 1'b0;
        bit did_rst = 1'b0;
        bit finished = 1'b0;
        bit served = 1'b0;
        bit in_resp;

        for (int w = 0; w < 100 && (due_q.size() > 0 || busy_o); w++) @(negedge clk_i);
        @(negedge clk_i);
        #1;
        seed       = $urandom;
        acc_cnt    = 0;
        deliv_cnt  = 0;
        acc_addr.delete();
        pat_idx    = 0;
        ready_mode = rmode;
        lat_mode   = lmode;
        lowx_req_addr_i     = a;
        lowx_req_uncached_i = unc;

        nb      = unc ? 1 : BEATS;
        base    = unc ? {a[31:2], 2'b00} : {a[31:4], 4'b0000};
        exp_blk = '0;
        for (int i = 0; i < nb; i++) begin
            lane = unc ? int'(a[3:2]) : i;
            exp_blk[32*lane +: 32] = memWord(base + 32'(4 * i));
        end

        for (int s = 0; s < 300 && !finished; s++) begin
            @(negedge clk_i);
            #1;
            if (did_rst) begin
                rst_i = 1'b0;
                #1;
                checkOutput("rst_res_valid", lowx_res_valid_o, 0);
                checkOutput("rst_blk", lowx_res_blk_o, 0);
                checkOutput("rst_mem_valid", mem_req_valid_o, 0);
                checkOutput("rst_mem_addr", mem_req_addr_o, 0);
                checkOutput("rst_busy", busy_o, 0);
                finished = 1'b1;
            end else if (rst_at >= 0 && prev_acc >= rst_at) begin
                rst_i            = 1'b1;
                lowx_req_valid_i = 1'b0;
                lowx_req_ready_i = 1'b0;
                did_rst          = 1'b1;
            end else begin
                if (drop_at >= 0 && prev_acc >= drop_at) dropped = 1'b1;
                in_resp          = !dropped && (prev_deliv >= nb);
                lowx_req_valid_i = !dropped;
                lowx_req_ready_i = !dropped && (in_resp ? (stalls >= stall) : (stall == 0));
                #1;
                if (in_resp && !lowx_req_ready_i) begin
                    checkOutput("stall_no_valid", lowx_res_valid_o, 0);
                    checkOutput("stall_blk", lowx_res_blk_o, exp_blk);
                    stalls = stalls + 1;
                end else if (in_resp) begin
                    checkOutput("res_valid", lowx_res_valid_o, 1);
                    checkOutput("res_blk", lowx_res_blk_o, exp_blk);
                    served   = 1'b1;
                    finished = 1'b1;
                end else if (lowx_res_valid_o) begin
                    pulses = pulses + 1;
                end
                if (dropped && prev_deliv >= nb && !busy_o) finished = 1'b1;
            end
            prev_acc   = acc_cnt;
            prev_deliv = deliv_cnt;
        end
        checkOutput("finish_in_time", finished, 1);
        checkOutput("no_stray_pulse", pulses, 0);

        if (served) begin
            @(negedge clk_i);
            #1;
            lowx_req_valid_i = 1'b1;
            lowx_req_ready_i = 1'b1;
            #1;
            checkOutput("pulse_one_cycle", lowx_res_valid_o, 0);
        end
        if (!did_rst) begin
            repeat (3) begin
                @(negedge clk_i);
                #1;
                lowx_req_valid_i = 1'b0;
                lowx_req_ready_i = 1'b0;
                #1;
                checkOutput("idle_no_res", lowx_res_valid_o, 0);
            end
            checkOutput("beats_issued", acc_cnt, nb);
            checkOutput("busy_clear", busy_o, 0);
            for (int i = 0; i < nb && i < acc_addr.size(); i++) begin
                checkOutput("mem_addr", acc_addr[i], base + 32'(4 * i));
            end
        end
        lowx_req_valid_i = 1'b0;
        lowx_req_ready_i = 1'b0;
    endtask

    // Directed scenarios followed by randomized misses.
    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("reset_res_valid", lowx_res_valid_o, 0);
        checkOutput("reset_blk", lowx_res_blk_o, 0);
        checkOutput("reset_mem_valid", mem_req_valid_o, 0);
        checkOutput("reset_mem_addr", mem_req_addr_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        rst_i = 1'b0;

        applyStimulus(32'h0000_1234, 1'b0, 0, 0, 0, -1, -1);
        force_en  = 1'b1;
        force_val = 32'hDEAD_BEEF;
        applyStimulus(32'h0000_2008, 1'b1, 0, 0, 0, -1, -1);
        force_en  = 1'b0;
        applyStimulus($urandom, 1'b0, 1, 0, 0, -1, -1);
        applyStimulus($urandom, 1'b0, 0, 1, 3, -1, -1);
        applyStimulus(32'h0000_0100, 1'b0, 0, 0, 0, 2, -1);
        applyStimulus(32'h0000_0040, 1'b0, 0, 0, 0, -1, -1);
        applyStimulus(32'h0000_0300, 1'b0, 0, 0, 0, -1, 2);
        applyStimulus(32'h0000_0300, 1'b0, 0, 0, 0, -1, -1);

        for (int t = 0; t < 20; t++) begin
            applyStimulus($urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? 2 : 0, 1,
                          $urandom_range(0, 2),
                          ($urandom_range(0, 3) == 0) ? 1 : -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
